countdown_bcd_timer: RTL and testbench
======================================

COUNTDOWN_BCD_TIMER -- requirements
Module: countdown_bcd_timer

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 Parameter: TICK_DIV, 100_000_000, clk cycles per one-second tick (minimum 2).
REQ-003 Port: clk  in  1  system clock, all state on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 Port: max_time  in  8  countdown start value in binary seconds (0..255), sampled on start only.
REQ-006 Port: start  in  1  single-cycle pulse; (re)load max_time and begin counting.
REQ-007 Port: pause  in  1  single-cycle pulse; toggles RUN/PAUSE.
REQ-008 Port: hundreds  out  4  BCD hundreds digit of remaining time.
REQ-009 Port: tens  out  4  BCD tens digit.
REQ-010 Port: ones  out  4  BCD ones digit.
REQ-011 Port: running  out  1  high while in RUN.
REQ-012 Port: busy  out  1  high while in LOAD.
REQ-013 Port: time_up  out  1  single-cycle pulse when the count reaches 000.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, RUN, PAUSE, DONE.
REQ-015 start in any state SHALL go to LOAD on the next edge, capture max_time into an 8-bit shift register, and clear the prescaler.
REQ-016 LOAD SHALL perform an 8-step shift-add-3 binary-to-BCD conversion, one step per cycle: busy high for exactly 8 cycles.
REQ-017 Digit outputs SHALL hold their previous values during LOAD and update together on LOAD exit.
REQ-018 LOAD exit SHALL go to RUN if the converted value is non-zero, else to DONE with time_up asserted in the same cycle as the DONE entry.
REQ-019 In RUN the prescaler SHALL count 0..TICK_DIV-1 and wrap: on the wrap cycle the BCD value SHALL decrement by one.
REQ-020 Decrement SHALL borrow per digit: ones 0->9 borrows from tens, tens 0->9 borrows from hundreds; digits never exceed 9.
REQ-021 The decrement that yields 000 SHALL move the FSM to DONE and pulse time_up for exactly one cycle.
REQ-022 pause in RUN SHALL go to PAUSE, freezing the prescaler and the digits: pause in PAUSE SHALL return to RUN, with the prescaler resuming from its frozen value.
REQ-023 pause in IDLE, LOAD or DONE SHALL be ignored.
REQ-024 start and pause in the same cycle SHALL act as start only.
REQ-025 start during LOAD SHALL restart conversion with the newly sampled max_time.
REQ-026 Changes on max_time outside a start cycle SHALL have no effect.
REQ-027 DONE SHALL hold digits at 000 until start.
REQ-028 running SHALL equal (state==RUN), and busy SHALL equal (state==LOAD).
REQ-029 Both running and busy SHALL be registered, not combinational from the inputs.

Reset
REQ-030 reset low SHALL force IDLE, hundreds=tens=ones=0, prescaler=0, running=0, busy=0, time_up=0, asynchronously.
REQ-031 reset asserted mid-LOAD, mid-RUN or in PAUSE SHALL abandon the operation, with no time_up pulse.
REQ-032 After reset release, the block SHALL stay in IDLE until start.

Verification (TICK_DIV=4)
REQ-033 max_time=8'd123, start -> busy high for 8 cycles, then digits 1/2/3 and running=1.
REQ-034 From 1/0/0 in RUN -> after 4 cycles digits 0/9/9: borrow chain verified.
REQ-035 max_time=3, start -> 3 decrements 4 cycles apart, then time_up is a 1-cycle pulse with digits 000 and running=0.
REQ-036 max_time=0, start -> after 8 LOAD cycles DONE entered, time_up pulses once, running never high.
REQ-037 RUN with prescaler=2, pause held off for 20 cycles then pause again -> digits unchanged while paused, next decrement 2 cycles after resume.
REQ-038 start+pause same cycle during RUN with max_time=255 -> LOAD, then 2/5/5: reset pulse mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/countdown_bcd_timer.sv
// rtl/countdown_bcd_timer.sv - countdown timer with serial binary-to-BCD load and BCD borrow decrement
// A start loads max_time through an 8-step double-dabble, then the BCD value counts down once per TICK_DIV clocks.
module countdown_bcd_timer #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] max_time,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       busy,
  output logic       time_up
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        r_state;
  logic [7:0]    r_shift;
  logic          r_wh;
  logic [3:0]    r_wt;
  logic [3:0]    r_wo;
  logic [2:0]    r_step;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_hundreds;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;
  logic          r_running;
  logic          r_busy;
  logic          r_time_up;

  function automatic logic [3:0] f_add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Before the final shift the partial value is at most 127, so one hundreds bit suffices in the working register.
  logic [3:0] w_adj_t;
  logic [3:0] w_adj_o;
  logic [1:0] w_nh;
  logic [3:0] w_nt;
  logic [3:0] w_no;
  logic       w_load_zero;
  assign w_adj_t     = f_add3(r_wt);
  assign w_adj_o     = f_add3(r_wo);
  assign w_nh        = {r_wh, w_adj_t[3]};
  assign w_nt        = {w_adj_t[2:0], w_adj_o[3]};
  assign w_no        = {w_adj_o[2:0], r_shift[7]};
  assign w_load_zero = (w_nh == 2'd0) && (w_nt == 4'd0) && (w_no == 4'd0);

  logic [3:0] w_dec_h;
  logic [3:0] w_dec_t;
  logic [3:0] w_dec_o;
  logic       w_at_one;
  assign w_dec_o  = (r_ones == 4'd0) ? 4'd9 : r_ones - 4'd1;
  assign w_dec_t  = (r_ones != 4'd0) ? r_tens : ((r_tens == 4'd0) ? 4'd9 : r_tens - 4'd1);
  assign w_dec_h  = ((r_ones == 4'd0) && (r_tens == 4'd0)) ? r_hundreds - 4'd1 : r_hundreds;
  assign w_at_one = (r_hundreds == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shift    <= 8'd0;
      r_wh       <= 1'b0;
      r_wt       <= 4'd0;
      r_wo       <= 4'd0;
      r_step     <= 3'd0;
      r_presc    <= '0;
      r_hundreds <= 4'd0;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_running  <= 1'b0;
      r_busy     <= 1'b0;
      r_time_up  <= 1'b0;
    end else begin
      r_time_up <= 1'b0;
      if (start) begin
        r_state   <= S_LOAD;
        r_shift   <= max_time;
        r_wh      <= 1'b0;
        r_wt      <= 4'd0;
        r_wo      <= 4'd0;
        r_step    <= 3'd0;
        r_presc   <= '0;
        r_busy    <= 1'b1;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            r_shift <= {r_shift[6:0], 1'b0};
            r_wh    <= w_nh[0];
            r_wt    <= w_nt;
            r_wo    <= w_no;
            r_step  <= r_step + 3'd1;
            if (r_step == 3'd7) begin
              r_hundreds <= {2'b00, w_nh};
              r_tens     <= w_nt;
              r_ones     <= w_no;
              r_busy     <= 1'b0;
              if (w_load_zero) begin
                r_state   <= S_DONE;
                r_time_up <= 1'b1;
              end else begin
                r_state   <= S_RUN;
                r_running <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (pause) begin
              r_state   <= S_PAUSE;
              r_running <= 1'b0;
            end else if (r_presc == P_LAST) begin
              r_presc    <= '0;
              r_hundreds <= w_dec_h;
              r_tens     <= w_dec_t;
              r_ones     <= w_dec_o;
              if (w_at_one) begin
                r_state   <= S_DONE;
                r_running <= 1'b0;
                r_time_up <= 1'b1;
              end
            end else begin
              r_presc <= r_presc + P_ONE;
            end
          end
          S_PAUSE: begin
            if (pause) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hundreds = r_hundreds;
  assign tens     = r_tens;
  assign ones     = r_ones;
  assign running  = r_running;
  assign busy     = r_busy;
  assign time_up  = r_time_up;
endmodule

// File: tb/tb_countdown_bcd_timer.sv
// tb/tb_countdown_bcd_timer.sv - scoreboard bench for countdown_bcd_timer at TICK_DIV=4
module tb_countdown_bcd_timer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] max_time = 8'd0;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       busy;
  logic       time_up;

  int          n_vec = 0;
  int          n_err = 0;
  logic [12:0] sb_q[$];
  logic [11:0] mon_prev = 12'h000;
  logic [12:0] mon_obs;

  countdown_bcd_timer #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .max_time(max_time), .start(start), .pause(pause),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .running(running), .busy(busy), .time_up(time_up)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic expect_val(input int n, input logic tu);
    sb_q.push_back({to_bcd(n), tu});
  endtask

  // Every digit change or time_up pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      mon_prev = 12'h000;
    end else begin
      mon_obs = {hundreds, tens, ones, time_up};
      if (({hundreds, tens, ones} != mon_prev) || time_up) begin
        if (sb_q.size() == 0) check("sb_unexpected", 32'(sb_q.size()), 32'd1);
        else check("sb", 32'(mon_obs), 32'(sb_q.pop_front()));
      end
      mon_prev = {hundreds, tens, ones};
    end
  end

  task automatic do_start(input logic [7:0] v, input logic with_pause);
    max_time = v;
    start = 1'b1;
    pause = with_pause;
    @(posedge clk);
    #1;
    start = 1'b0;
    pause = 1'b0;
    max_time = 8'($urandom);
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    @(posedge clk);
    #1;
    pause = 1'b0;
  endtask

  task automatic wait_load(output int nb);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) nb++;
      else break;
    end
  endtask

  task automatic wait_change(output int cyc);
    logic [11:0] old;
    old = {hundreds, tens, ones};
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if ({hundreds, tens, ones} != old) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c;
    #2 reset = 1'b0;
    #1;
    check("reset_state", 32'({hundreds, tens, ones, running, busy, time_up}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    pulse_pause();
    @(negedge clk);
    check("idle_after_reset", 32'({hundreds, tens, ones, running, busy, time_up}), 32'd0);

    expect_val(123, 1'b0);
    do_start(8'd123, 1'b0);
    wait_load(n);
    check("load_busy_cycles", 32'(n), 32'd8);
    check("run_after_load", 32'(running), 32'd1);

    expect_val(100, 1'b0);
    expect_val(99, 1'b0);
    do_start(8'd100, 1'b0);
    @(negedge clk);
    check("hold_in_load", 32'({hundreds, tens, ones}), 32'h123);
    wait_load(n);
    check("load_busy_rest", 32'(n), 32'd7);
    wait_change(c);
    check("borrow_gap", 32'(c), 32'd4);

    expect_val(3, 1'b0);
    expect_val(2, 1'b0);
    expect_val(1, 1'b0);
    expect_val(0, 1'b1);
    do_start(8'd3, 1'b0);
    wait_load(n);
    for (int k = 0; k < 3; k++) begin
      wait_change(c);
      check("dec_gap", 32'(c), 32'd4);
    end
    check("time_up_high", 32'(time_up), 32'd1);
    check("done_not_running", 32'(running), 32'd0);
    @(negedge clk);
    check("time_up_one_cycle", 32'(time_up), 32'd0);
    repeat (8) @(negedge clk);

    expect_val(0, 1'b1);
    do_start(8'd0, 1'b0);
    wait_load(n);
    check("zero_busy_cycles", 32'(n), 32'd8);
    check("zero_time_up", 32'(time_up), 32'd1);
    check("zero_not_running", 32'(running), 32'd0);
    pulse_pause();
    c = 0;
    repeat (10) begin
      @(negedge clk);
      if (running) c++;
    end
    check("zero_never_runs", 32'(c), 32'd0);

    expect_val(50, 1'b0);
    expect_val(49, 1'b0);
    do_start(8'd50, 1'b0);
    wait_load(n);
    @(posedge clk);
    @(posedge clk);
    #1;
    pulse_pause();
    repeat (20) @(negedge clk);
    check("paused_digits", 32'({hundreds, tens, ones}), 32'h050);
    check("paused_not_running", 32'(running), 32'd0);
    pulse_pause();
    @(negedge clk);
    check("resumed_running", 32'(running), 32'd1);
    wait_change(c);
    check("resume_gap", 32'(c), 32'd2);

    expect_val(45, 1'b0);
    do_start(8'd200, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    do_start(8'd45, 1'b0);
    pulse_pause();
    wait_load(n);
    check("restart_busy_rest", 32'(n), 32'd7);
    check("restart_running", 32'(running), 32'd1);

    expect_val(255, 1'b0);
    do_start(8'd255, 1'b1);
    wait_load(n);
    check("start_pause_busy", 32'(n), 32'd8);
    check("start_pause_running", 32'(running), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_reset_run", 32'({hundreds, tens, ones, running, busy, time_up}), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    c = 0;
    repeat (10) begin
      @(negedge clk);
      if (time_up || running || busy) c++;
    end
    check("quiet_after_reset", 32'(c), 32'd0);

    do_start(8'd9, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_reset_load", 32'({hundreds, tens, ones, running, busy, time_up}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (12) @(negedge clk);
    check("idle_after_load_reset", 32'({hundreds, tens, ones, running, busy}), 32'd0);

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
